// File: rtl/vga_pkg.sv
// Shared VGA timing presets, the aligned-control bundle type and timing helper functions.
package vga_pkg;

  localparam int VGA640_HACTIVE = 640;
  localparam int VGA640_HFP     = 16;
  localparam int VGA640_HSYNC   = 96;
  localparam int VGA640_HBP     = 48;
  localparam int VGA640_VACTIVE = 480;
  localparam int VGA640_VFP     = 10;
  localparam int VGA640_VSYNC   = 2;
  localparam int VGA640_VBP     = 33;

  localparam int VGA800_HACTIVE = 800;
  localparam int VGA800_HFP     = 40;
  localparam int VGA800_HSYNC   = 128;
  localparam int VGA800_HBP     = 88;
  localparam int VGA800_VACTIVE = 600;
  localparam int VGA800_VFP     = 1;
  localparam int VGA800_VSYNC   = 4;
  localparam int VGA800_VBP     = 23;

  // Control signals that travel together through the latency-matching delay line.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic frame_start;
    logic line_start;
  } vga_ctrl_t;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // A CW-bit counter can reach total-1 only when clog2(total) <= CW.
  function automatic bit vga_width_fits(input int total, input int cw);
    return $clog2(total) <= cw;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Shift register of DEPTH stages with per-bit async reset value; tap is the stage before the output.
module vga_delay_line #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [W-1:0] tap
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

  // With a single stage the tap is the undelayed input.
  if (DEPTH > 1) begin : g_tap_reg
    assign tap = stage[DEPTH-2];
  end else begin : g_tap_comb
    assign tap = din;
  end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan generator: h/v timing, framebuffer address with frame-latched base/scale, latency-aligned outputs.
// Define VGA_SCAN_SCALE_EN to honour the 2x replication input; otherwise scale is ignored.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int HACTIVE = 640,
  parameter int HFP     = 16,
  parameter int HSYNC   = 96,
  parameter int HBP     = 48,
  parameter int VACTIVE = 480,
  parameter int VFP     = 10,
  parameter int VSYNC   = 2,
  parameter int VBP     = 33,
  parameter bit HPOL    = 1'b0,
  parameter bit VPOL    = 1'b0,
  parameter int CW      = 12,
  parameter int ADDR_W  = 19,
  parameter int STRIDE  = 640,
  parameter int PIX_W   = 8,
  parameter int LAT     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              scale,
  input  logic [PIX_W-1:0]  pix_in,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [PIX_W-1:0]  pix_out,
  output logic              frame_start,
  output logic              line_start
);

  localparam int HTOTAL = vga_total(HACTIVE, HFP, HSYNC, HBP);
  localparam int VTOTAL = vga_total(VACTIVE, VFP, VSYNC, VBP);

  localparam logic [CW-1:0] H_LAST = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(HACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(HACTIVE + HFP);
  localparam logic [CW-1:0] HS_END = CW'(HACTIVE + HFP + HSYNC);
  localparam logic [CW-1:0] V_LAST = CW'(VTOTAL - 1);
  localparam logic [CW-1:0] V_ACT  = CW'(VACTIVE);
  localparam logic [CW-1:0] VS_BEG = CW'(VACTIVE + VFP);
  localparam logic [CW-1:0] VS_END = CW'(VACTIVE + VFP + VSYNC);

  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
  localparam vga_ctrl_t CTRL_RST = '{hsync: ~HPOL, vsync: ~VPOL, default: 1'b0};

  if (!vga_width_fits(HTOTAL, CW) || !vga_width_fits(VTOTAL, CW)) begin : g_cw_check
    $error("vga_scan_gen: CW too narrow for HTOTAL/VTOTAL");
  end
  if (LAT < 0) begin : g_lat_check
    $error("vga_scan_gen: LAT must be non-negative");
  end

  logic [CW-1:0]     h;
  logic [CW-1:0]     v;
  logic [CW-1:0]     h_off;
  logic              line_end;
  logic              frame_end;
  logic              line_adv;
  logic              raw_active;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] addr_calc;
  logic [ADDR_W-1:0] addr_hold;
  vga_ctrl_t         raw_ctrl;
  vga_ctrl_t         dly_ctrl;
  vga_ctrl_t         tap_ctrl;
  logic [3:0]        tap_unused;

  assign line_end   = (h == H_LAST);
  assign frame_end  = line_end && (v == V_LAST);
  assign raw_active = (h < H_ACT) && (v < V_ACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (line_end) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

`ifdef VGA_SCAN_SCALE_EN
  logic scale_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         scale_q <= 1'b0;
    else if (frame_end) scale_q <= scale;
  end

  // Replication: each pixel read twice, each line's base reused for two lines.
  assign h_off    = scale_q ? (h >> 1) : h;
  assign line_adv = !scale_q || v[0];
`else
  logic scale_unused;

  assign scale_unused = scale;
  assign h_off        = h;
  assign line_adv     = 1'b1;
`endif

  // line_base takes the base being latched at the wrap so the new page starts on the very next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      line_base <= '0;
    end else if (frame_end) begin
      base_q    <= fb_base;
      line_base <= fb_base;
    end else if (line_end && (v < V_ACT) && line_adv) begin
      line_base <= line_base + STRIDE_A;
    end
  end

  assign addr_calc = line_base + ADDR_W'(h_off);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          addr_hold <= '0;
    else if (raw_active) addr_hold <= addr_calc;
  end

  assign addr       = raw_active ? addr_calc : addr_hold;
  assign addr_valid = raw_active;

  always_comb begin
    raw_ctrl             = CTRL_RST;
    raw_ctrl.hsync       = ((h >= HS_BEG) && (h < HS_END)) ? HPOL : ~HPOL;
    raw_ctrl.vsync       = ((v >= VS_BEG) && (v < VS_END)) ? VPOL : ~VPOL;
    raw_ctrl.de          = raw_active;
    raw_ctrl.frame_start = (h == '0) && (v == '0);
    raw_ctrl.line_start  = (h == '0) && (v < V_ACT);
  end

  vga_delay_line #(
    .W      ($bits(vga_ctrl_t)),
    .DEPTH  (LAT + 1),
    .RST_VAL(CTRL_RST)
  ) u_ctrl_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (raw_ctrl),
    .dout (dly_ctrl),
    .tap  (tap_ctrl)
  );

  assign tap_unused = {tap_ctrl.hsync, tap_ctrl.vsync, tap_ctrl.frame_start, tap_ctrl.line_start};

  // The tap's de lines up with read data arriving LAT cycles after its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_out <= '0;
    else        pix_out <= tap_ctrl.de ? pix_in : '0;
  end

  assign hsync       = dly_ctrl.hsync;
  assign vsync       = dly_ctrl.vsync;
  assign de          = dly_ctrl.de;
  assign frame_start = dly_ctrl.frame_start;
  assign line_start  = dly_ctrl.line_start;

endmodule
